multicycle_control: RTL and testbench

Multi-cycle control FSM for the RISC-V datapath, successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives per-cycle datapath enables and a request/ready memory handshake, runs a watchdog on memory waits, and traps on illegal opcodes. It sits between the instruction register and the shared datapath (PC, IR, register file, ALU, unified memory).

---
 rtl/ctrl_pkg.sv | 76 +++++++
 rtl/mem_watchdog.sv | 31 +++
 rtl/multicycle_control.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types, opcode values and datapath encodings for the multi-cycle control FSM.
// Defining CTRL_JUMP_EN makes JAL/JALR/LUI decode as legal classes instead of ILL.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R,
        C_IALU,
        C_LOAD,
        C_STORE,
        C_BR,
        C_JAL,
        C_JALR,
        C_LUI,
        C_ILL
    } op_class_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [1:0] SRC_A_PC   = 2'd0;
    localparam logic [1:0] SRC_A_RS1  = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILL     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

`ifdef CTRL_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    // With jumps disabled the jump classes never leave decode, so jump/link stay constant 0.
    function automatic op_class_t decode_class(input logic [6:0] op);
        op_class_t c;
        case (op)
            OP_R:     c = C_R;
            OP_IALU:  c = C_IALU;
            OP_LOAD:  c = C_LOAD;
            OP_STORE: c = C_STORE;
            OP_BR:    c = C_BR;
            OP_JAL:   c = JUMP_EN ? C_JAL  : C_ILL;
            OP_JALR:  c = JUMP_EN ? C_JALR : C_ILL;
            OP_LUI:   c = JUMP_EN ? C_LUI  : C_ILL;
            default:  c = C_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory-wait watchdog shared by FETCH and MEM: counts waiting cycles since the
// last clear and flags once TIMEOUT waiting cycles have elapsed.
module mem_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic wait_cycle,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Saturates at the limit so a stalled access can never wrap back below it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wait_cycle && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back with a
// mem_req/mem_ready handshake, watchdog and sticky error. CTRL_JUMP_EN adds JAL/JALR/LUI.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               branch,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               jump,
    output logic               link,
    output logic [1:0]         err
);

    state_t    state, next_state;
    op_class_t cls, dec_cls;
    logic [1:0] err_q, trap_code;
    logic [1:0] op2;
    logic       wd_clear, wd_wait, wd_timeout;

    assign dec_cls = decode_class(opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
            cls   <= C_ILL;
            err_q <= ERR_NONE;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                cls <= dec_cls;
            end
            if (next_state == S_TRAP && state != S_TRAP) begin
                err_q <= trap_code;
            end
        end
    end

    // The watchdog restarts whenever a fresh memory access phase begins.
    assign wd_clear = (next_state != state) && (next_state == S_FETCH || next_state == S_MEM);

    mem_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (wd_clear),
        .wait_cycle(wd_wait),
        .timeout   (wd_timeout)
    );

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        op2        = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        jump       = 1'b0;
        link       = 1'b0;
        wd_wait    = 1'b0;
        trap_code  = ERR_NONE;
        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = SRC_B_FOUR;
                    next_state = S_DECODE;
                end else if (wd_timeout) begin
                    next_state = S_TRAP;
                    trap_code  = ERR_TIMEOUT;
                end else begin
                    wd_wait = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM;
                if (dec_cls == C_ILL) begin
                    next_state = S_TRAP;
                    trap_code  = ERR_ILL;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                next_state = S_WB;
                case (cls)
                    C_R: begin
                        alu_src_b = SRC_B_RS2;
                        op2       = ALU_RTYPE;
                    end
                    C_IALU: op2 = ALU_ITYPE;
                    C_LOAD, C_STORE: next_state = S_MEM;
                    C_BR: begin
                        alu_src_b  = SRC_B_RS2;
                        op2        = ALU_SUB;
                        branch     = 1'b1;
                        next_state = S_FETCH;
                    end
                    C_JAL: begin
                        alu_src_a = SRC_A_PC;
                        jump      = 1'b1;
                        pc_write  = 1'b1;
                    end
                    C_JALR: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                    end
                    C_LUI: alu_src_a = SRC_A_ZERO;
                    default: begin
                        next_state = S_TRAP;
                        trap_code  = ERR_ILL;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = (cls == C_STORE);
                if (mem_ready) begin
                    next_state = (cls == C_LOAD) ? S_WB : S_FETCH;
                end else if (wd_timeout) begin
                    next_state = S_TRAP;
                    trap_code  = ERR_TIMEOUT;
                end else begin
                    wd_wait = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == C_LOAD);
                link       = (cls == C_JAL) || (cls == C_JALR);
                next_state = S_FETCH;
            end
            S_TRAP: next_state = S_TRAP;
            default: next_state = S_RESET;
        endcase
    end

    assign alu_op = ALUOP_W'(op2);
    assign err    = err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed and random instructions checked
// against per-instruction expectations derived from the instruction timing rules.
module tb_multicycle_control;

    localparam int ALUOP_W = 2;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_IALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

`ifdef CTRL_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic [6:0]         opcode;
    logic               mem_ready;
    logic               mem_req, mem_we, i_or_d, ir_write, pc_write, branch;
    logic [1:0]         alu_src_a, alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_write, mem_to_reg, jump, link;
    logic [1:0]         err;

    typedef struct packed {
        logic               mem_req;
        logic               mem_we;
        logic               i_or_d;
        logic               ir_write;
        logic               pc_write;
        logic               branch;
        logic [1:0]         a;
        logic [1:0]         b;
        logic [ALUOP_W-1:0] op;
        logic               reg_write;
        logic               mem_to_reg;
        logic               jump;
        logic               link;
        logic [1:0]         err;
    } snap_t;

    typedef struct {
        int cycles;
        int irw, pcw, regw, memwe, memreq, br, m2r, jmp, lnk, errc, err;
    } exp_t;

    snap_t cur;
    snap_t trace[$];
    logic [6:0] legal [8] = '{OPC_R, OPC_IALU, OPC_LOAD, OPC_STORE, OPC_BR, OPC_JAL, OPC_JALR, OPC_LUI};

    int total = 0;
    int bad   = 0;
    int fetchWait, memWait, reqLen;
    bit prevReq, prevIod, prevDone;

    assign cur = {mem_req, mem_we, i_or_d, ir_write, pc_write, branch, alu_src_a, alu_src_b,
                  alu_op, reg_write, mem_to_reg, jump, link, err};

    multicycle_control #(
        .ALUOP_W(ALUOP_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .i_or_d    (i_or_d),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .branch    (branch),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .mem_to_reg(mem_to_reg),
        .jump      (jump),
        .link      (link),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic int classOf(input logic [6:0] opc);
        case (opc)
            OPC_R:     return 0;
            OPC_IALU:  return 1;
            OPC_LOAD:  return 2;
            OPC_STORE: return 3;
            OPC_BR:    return 4;
            OPC_JAL:   return JUMP_EN ? 5 : 8;
            OPC_JALR:  return JUMP_EN ? 6 : 8;
            OPC_LUI:   return JUMP_EN ? 7 : 8;
            default:   return 8;
        endcase
    endfunction

    // Expected activity for one instruction from its class, wait counts and trap rules.
    function automatic exp_t model(input logic [6:0] opc, input int fw, input int mw, input int hold);
        exp_t e;
        int k;
        bit isMem, isJump;
        e = '{default: 0};
        k = classOf(opc);
        isMem  = (k == 2) || (k == 3);
        isJump = (k == 5) || (k == 6);
        if (fw > TIMEOUT) begin
            e.memreq = TIMEOUT + 1;
            e.cycles = TIMEOUT + 1 + hold;
            e.errc   = hold;
            e.err    = 2;
            return e;
        end
        e.irw    = 1;
        e.pcw    = 1;
        e.memreq = fw + 1;
        if (k == 8) begin
            e.cycles = fw + 2 + hold;
            e.errc   = hold;
            e.err    = 1;
            return e;
        end
        if (isMem && mw > TIMEOUT) begin
            e.memreq += TIMEOUT + 1;
            e.memwe  = (k == 3) ? TIMEOUT + 1 : 0;
            e.cycles = fw + 3 + TIMEOUT + 1 + hold;
            e.errc   = hold;
            e.err    = 2;
            return e;
        end
        e.cycles = ((k == 4) ? 3 : (k == 2) ? 5 : 4) + fw + (isMem ? mw : 0);
        if (isMem) e.memreq += mw + 1;
        if (k == 3) e.memwe = mw + 1;
        e.regw = (k == 3 || k == 4) ? 0 : 1;
        e.br   = (k == 4) ? 1 : 0;
        e.m2r  = (k == 2) ? 1 : 0;
        e.jmp  = isJump ? 1 : 0;
        e.lnk  = isJump ? 1 : 0;
        e.pcw += e.jmp;
        return e;
    endfunction

    // Runs one instruction (entered at posedge+1 in FETCH), acting as the memory.
    task automatic applyStimulus(input string name, input logic [6:0] opc, input int fw,
                                 input int mw, input int hold);
        exp_t e;
        int irw, pcw, regw, memwe, memreq, br, m2r, jmp, lnk, errc;
        e = model(opc, fw, mw, hold);
        opcode = opc;
        fetchWait = fw;
        memWait = mw;
        trace.delete();
        for (int c = 0; c < e.cycles; c++) begin
            if (mem_req) begin
                if (!prevReq || prevIod != i_or_d || prevDone) reqLen = 0;
                else reqLen++;
                mem_ready = (reqLen == (i_or_d ? memWait : fetchWait));
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            prevReq  = mem_req;
            prevIod  = i_or_d;
            prevDone = mem_req && mem_ready;
            @(negedge clk);
            trace.push_back(cur);
            @(posedge clk);
            #1;
        end
        {irw, pcw, regw, memwe, memreq, br, m2r, jmp, lnk, errc} = '0;
        foreach (trace[i]) begin
            irw    += int'(trace[i].ir_write);
            pcw    += int'(trace[i].pc_write);
            regw   += int'(trace[i].reg_write);
            memwe  += int'(trace[i].mem_we);
            memreq += int'(trace[i].mem_req);
            br     += int'(trace[i].branch);
            m2r    += int'(trace[i].mem_to_reg);
            jmp    += int'(trace[i].jump);
            lnk    += int'(trace[i].link);
            errc   += (trace[i].err != 2'b00) ? 1 : 0;
            if (trace[i].branch)
                checkOutput({name, " branch alu_op"}, 32'(trace[i].op), 32'(2'b01));
        end
        checkOutput({name, " ir_write"}, irw, e.irw);
        checkOutput({name, " pc_write"}, pcw, e.pcw);
        checkOutput({name, " reg_write"}, regw, e.regw);
        checkOutput({name, " mem_we"}, memwe, e.memwe);
        checkOutput({name, " mem_req"}, memreq, e.memreq);
        checkOutput({name, " branch"}, br, e.br);
        checkOutput({name, " mem_to_reg"}, m2r, e.m2r);
        checkOutput({name, " jump"}, jmp, e.jmp);
        checkOutput({name, " link"}, lnk, e.lnk);
        checkOutput({name, " err cycles"}, errc, e.errc);
        checkOutput({name, " final err"}, 32'(trace[trace.size()-1].err), e.err);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("async reset outputs", 32'(cur), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prevReq = 1'b0;
        prevIod = 1'b0;
        prevDone = 1'b0;
        reqLen = 0;
        @(negedge clk);
        checkOutput("RESET state outputs", 32'(cur), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("first FETCH mem_req", 32'(mem_req), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = 7'd0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        doReset();

        applyStimulus("rtype", OPC_R, 0, 0, 0);
        checkOutput("rtype fetch ir_write", 32'(trace[0].ir_write), 32'd1);
        checkOutput("rtype fetch src_b", 32'(trace[0].b), 32'd1);
        checkOutput("rtype decode src_b", 32'(trace[1].b), 32'd2);
        checkOutput("rtype exec alu_op", 32'(trace[2].op), 32'd2);
        checkOutput("rtype exec src_a", 32'(trace[2].a), 32'd1);
        checkOutput("rtype exec reg_write", 32'(trace[2].reg_write), 32'd0);
        checkOutput("rtype wb reg_write", 32'(trace[3].reg_write), 32'd1);

        applyStimulus("load wait3", OPC_LOAD, 0, 3, 0);
        checkOutput("load mem i_or_d", 32'(trace[6].i_or_d), 32'd1);
        checkOutput("load wb mem_to_reg", 32'(trace[7].mem_to_reg), 32'd1);

        applyStimulus("store", OPC_STORE, 0, 0, 0);
        checkOutput("store mem_we cycle", 32'(trace[3].mem_we), 32'd1);
        applyStimulus("branch", OPC_BR, 0, 0, 0);
        checkOutput("branch exec", 32'(trace[2].branch), 32'd1);

        for (int i = 0; i < 30; i++) begin
            applyStimulus("random", legal[$urandom_range(0, JUMP_EN ? 7 : 4)],
                          $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        applyStimulus("fetch at limit", OPC_IALU, TIMEOUT, 0, 0);

        applyStimulus("illegal", 7'b1111111, 1, 0, 20);
        doReset();

        applyStimulus("fetch timeout", OPC_R, NEVER, 0, 4);
        doReset();

        applyStimulus("mem timeout", OPC_STORE, 0, NEVER, 3);
        doReset();

        applyStimulus("jal", OPC_JAL, 0, 0, JUMP_EN ? 0 : 3);
        if (JUMP_EN) begin
            checkOutput("jal exec jump", 32'(trace[2].jump), 32'd1);
            checkOutput("jal wb link", 32'(trace[3].link), 32'd1);
        end
        doReset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
